// File: rtl/ula_alu.sv
// ula_alu: 32-bit registered ALU for the Lapido datapath.
// Computes an arithmetic, logic or shift result from A and B under a 5-bit
// opcode and registers it with zero/negative/carry/overflow flags. Latency is
// one clock; the outputs update every cycle.
// Optional build macro ULA_BARREL_SHIFT_EN: when defined, lsl/asr shift A by
// B[4:0] positions instead of by one position.
module ula_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [4:0] {
    OP_ADD      = 5'b00000,
    OP_ADDINC   = 5'b00001,
    OP_INCA     = 5'b00010,
    OP_SUBDEC   = 5'b00011,
    OP_SUB      = 5'b00100,
    OP_DECA     = 5'b00101,
    OP_LSL      = 5'b00110,
    OP_ASR      = 5'b00111,
    OP_ZEROS    = 5'b01000,
    OP_AND      = 5'b01001,
    OP_ANDNOTA  = 5'b01010,
    OP_PASSB    = 5'b01011,
    OP_ANDNOTB  = 5'b01100,
    OP_PASSA    = 5'b01101,
    OP_XOR      = 5'b01110,
    OP_OR       = 5'b01111,
    OP_NOR      = 5'b10000,
    OP_XNOR     = 5'b10001,
    OP_PASSNOTA = 5'b10010,
    OP_ORNOTA   = 5'b10011,
    OP_PASSNOTB = 5'b10100,
    OP_ORNOTB   = 5'b10101,
    OP_NAND     = 5'b10110,
    OP_ONES     = 5'b10111
  } op_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Shared adder: subtraction is A + ~B + cin, so carry=1 means no borrow.
  logic [WIDTH-1:0] adder_b;
  logic             adder_cin;
  logic [WIDTH:0]   sum;

  // Next-state result and flags, registered below.
  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;

  // Select the second adder operand and carry-in for the arithmetic opcodes.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so opcodes not
    // listed below cannot leave a value held and infer a latch.
    adder_b   = '0;
    adder_cin = 1'b0;
    case (opcode)
      OP_ADD:    begin adder_b = B;    adder_cin = 1'b0; end
      OP_ADDINC: begin adder_b = B;    adder_cin = 1'b1; end
      OP_INCA:   begin adder_b = '0;   adder_cin = 1'b1; end
      OP_SUBDEC: begin adder_b = ~B;   adder_cin = 1'b0; end
      OP_SUB:    begin adder_b = ~B;   adder_cin = 1'b1; end
      OP_DECA:   begin adder_b = ~ONE; adder_cin = 1'b1; end
      default:   begin adder_b = '0;   adder_cin = 1'b0; end
    endcase
  end

  assign sum = {1'b0, A} + {1'b0, adder_b} + {{WIDTH{1'b0}}, adder_cin};

  // Pick the result and the carry/overflow flags for the current opcode.
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDINC, OP_INCA, OP_SUBDEC, OP_SUB, OP_DECA: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        // Adder operands of equal sign producing a result of the other sign.
        // For subtraction the operand is ~B, which covers "signs of A and B
        // differ and result sign differs from A".
        v = (A[WIDTH-1] == adder_b[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
`ifdef ULA_BARREL_SHIFT_EN
      OP_LSL: begin
        // Bit WIDTH of the widened shift is the last bit pushed out the top;
        // a zero shift leaves it clear.
        {c, r} = {1'b0, A} << B[4:0];
      end
      OP_ASR: begin
        // A guard bit below A catches the last bit shifted out the bottom.
        {r, c} = $signed({A, 1'b0}) >>> B[4:0];
      end
`else
      OP_LSL: begin
        r = {A[WIDTH-2:0], 1'b0};
        c = A[WIDTH-1];
        v = A[WIDTH-1] ^ A[WIDTH-2];
      end
      OP_ASR: begin
        r = {A[WIDTH-1], A[WIDTH-1:1]};
        c = A[0];
      end
`endif
      OP_ZEROS:    r = '0;
      OP_AND:      r = A & B;
      OP_ANDNOTA:  r = ~A & B;
      OP_PASSB:    r = B;
      OP_ANDNOTB:  r = A & ~B;
      OP_PASSA:    r = A;
      OP_XOR:      r = A ^ B;
      OP_OR:       r = A | B;
      OP_NOR:      r = ~(A | B);
      OP_XNOR:     r = ~(A ^ B);
      OP_PASSNOTA: r = ~A;
      OP_ORNOTA:   r = ~A | B;
      OP_PASSNOTB: r = ~B;
      OP_ORNOTB:   r = A | ~B;
      OP_NAND:     r = ~(A & B);
      OP_ONES:     r = '1;
      default:     r = '0;  // reserved opcodes
    endcase
  end

  // Register result and flags; reset forces a zero result with zero=1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Out      <= '0;
      zero     <= 1'b1;
      neg      <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      Out      <= r;
      zero     <= (r == '0);
      neg      <= r[WIDTH-1];
      carry    <= c;
      overflow <= v;
    end
  end

endmodule

// File: tb/tb_ula_alu.sv
// tb_ula_alu: self-checking bench for ula_alu. Directed vectors cover reset,
// wrap-around and the shift/logic corners; a randomized back-to-back run is
// checked against an arithmetic reference model using 64-bit integers.
module tb_ula_alu;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [4:0]   opcode;
  logic [W-1:0] Out;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         overflow;

  logic [35:0]  obs;
  assign obs = {Out, zero, neg, carry, overflow};

  int checks = 0;
  int errors = 0;

  ula_alu #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .Out      (Out),
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .overflow (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: {R, zero, neg, carry, overflow} from integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    longint ua, ub, sa, sb, u, s;
    logic [31:0] r;
    logic c, v;
    int kind;  // 0 none, 1 addition, 2 subtraction
    int n;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    u = 0; s = 0; r = '0; c = 1'b0; v = 1'b0; kind = 0;
    n = int'(b[4:0]);
    case (op)
      5'd0:  begin kind = 1; u = ua + ub;     s = sa + sb;     end
      5'd1:  begin kind = 1; u = ua + ub + 1; s = sa + sb + 1; end
      5'd2:  begin kind = 1; u = ua + 1;      s = sa + 1;      end
      5'd3:  begin kind = 2; u = ua - ub - 1; s = sa - sb - 1; end
      5'd4:  begin kind = 2; u = ua - ub;     s = sa - sb;     end
      5'd5:  begin kind = 2; u = ua - 1;      s = sa - 1;      end
`ifdef ULA_BARREL_SHIFT_EN
      5'd6: begin
        u = ua << n;
        r = u[31:0];
        c = (n == 0) ? 1'b0 : u[32];
      end
      5'd7: begin
        s = sa >>> n;
        r = s[31:0];
        c = (n == 0) ? 1'b0 : a[n-1];
      end
`else
      5'd6: begin
        s = sa * 2;
        r = 32'(ua * 2);
        c = a[31];
        v = (s > SMAX) || (s < SMIN);
      end
      5'd7: begin
        s = (sa - longint'(a[0])) / 2;  // floor of sa/2
        r = s[31:0];
        c = a[0];
      end
`endif
      5'd8:  r = 32'h0;
      5'd9:  r = a & b;
      5'd10: r = ~a & b;
      5'd11: r = b;
      5'd12: r = a & ~b;
      5'd13: r = a;
      5'd14: r = a ^ b;
      5'd15: r = a | b;
      5'd16: r = ~(a | b);
      5'd17: r = ~(a ^ b);
      5'd18: r = ~a;
      5'd19: r = ~a | b;
      5'd20: r = ~b;
      5'd21: r = a | ~b;
      5'd22: r = ~(a & b);
      5'd23: r = 32'hFFFF_FFFF;
      default: r = 32'h0;
    endcase
    if (kind != 0) begin
      r = u[31:0];
      v = (s > SMAX) || (s < SMIN);
      c = (kind == 1) ? (u > 64'sd4294967295) : (u >= 0);
    end
    return {r, (r == 32'h0), r[31], c, v};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Drive one operation and sample its registered result just after the edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    A = a;
    B = b;
    opcode = op;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    A = 32'($urandom);
    B = 32'($urandom);
    opcode = 5'd0;
    #1 reset_n = 1'b0;
    #1;  // still before the first rising edge
    checks++;
    if (obs !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", obs, {32'h0, 4'b1000});
    end
    for (int i = 0; i < 3; i++) begin
      A = 32'($urandom);
      B = 32'($urandom);
      opcode = 5'($urandom_range(0, 31));
      @(posedge clock);
      #1;
      checks++;
      if (obs !== {32'h0, 4'b1000}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, {32'h0, 4'b1000});
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] av [10] = '{32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h0,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h5, 32'hFFFF_FFFF};
    logic [31:0] bv [10] = '{32'h7FFF_FFFE, 32'h1, 32'h1, 32'h5, 32'h1,
                             32'h1, 32'h1234, 32'h9999, 32'h5, 32'h0};
    logic [4:0]  ov [10] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd4,
                             5'd4, 5'd2, 5'd5, 5'd3, 5'd1};
    logic [35:0] ev [10] = '{{32'h7FFF_FFFF, 4'b0000},
                             {32'h8000_0000, 4'b0101},
                             {32'h0000_0000, 4'b1010},
                             {32'h0000_0000, 4'b1010},
                             {32'hFFFF_FFFF, 4'b0100},
                             {32'h7FFF_FFFF, 4'b0011},
                             {32'h0000_0000, 4'b1010},
                             {32'hFFFF_FFFF, 4'b0100},
                             {32'hFFFF_FFFF, 4'b0100},
                             {32'h0000_0000, 4'b1010}};
    for (int i = 0; i < 10; i++) begin
      drive(av[i], bv[i], ov[i]);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL arith[%0d] op=%0d: got %h want %h", i, ov[i], obs, ev[i]);
      end
    end
  endtask

  task automatic test_shift();
`ifdef ULA_BARREL_SHIFT_EN
    logic [35:0] lsl_exp = {32'h0000_0002, 4'b0010};
`else
    logic [35:0] lsl_exp = {32'h0000_0002, 4'b0011};
`endif
    drive(32'h8000_0001, 32'h1, 5'd6);
    checks++;
    if (obs !== lsl_exp) begin
      errors++;
      $display("FAIL lsl: got %h want %h", obs, lsl_exp);
    end
    drive(32'h8000_0001, 32'h1, 5'd7);
    checks++;
    if (obs !== {32'hC000_0000, 4'b0110}) begin
      errors++;
      $display("FAIL asr: got %h want %h", obs, {32'hC000_0000, 4'b0110});
    end
  endtask

  task automatic test_logic();
    logic [4:0]  ov [5] = '{5'd9, 5'd14, 5'd16, 5'd23, 5'd31};
    logic [35:0] ev [5] = '{{32'hF000_F000, 4'b0100},
                            {32'h0FF0_0FF0, 4'b0000},
                            {32'h000F_000F, 4'b0000},
                            {32'hFFFF_FFFF, 4'b0100},
                            {32'h0000_0000, 4'b1000}};
    for (int i = 0; i < 5; i++) begin
      drive(32'hF0F0_F0F0, 32'hFF00_FF00, ov[i]);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL logic[%0d] op=%0d: got %h want %h", i, ov[i], obs, ev[i]);
      end
    end
  endtask

  // New inputs every cycle; each sample must match the previous edge's inputs.
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [35:0] exp;
    for (int i = 0; i < 400; i++) begin
      a = pick();
      b = pick();
      op = 5'($urandom_range(0, 31));
      exp = model(a, b, op);
      drive(a, b, op);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h op=%0d: got %h want %h", i, a, b, op, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp;
    drive(32'h1234_5678, 32'h1111_1111, 5'd0);  // leave a non-zero result
    reset_n = 1'b0;
    #2;
    checks++;
    if (obs !== {32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", obs, {32'h0, 4'b1000});
    end
    @(posedge clock);
    #1;
    A = 32'h7FFF_FFFF;
    B = 32'h0000_0001;
    opcode = 5'd0;
    reset_n = 1'b1;
    exp = model(A, B, opcode);
    @(posedge clock);
    #1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
